wildcat_uart_rx: RTL and testbench
==================================

# wildcat_uart_rx

UART receive front end for the Wildcat tile: oversamples the serial input pin, deserialises 8N1 frames and hands bytes to the ChiselTop core through a ready/valid port backed by a 2-entry buffer. It sits directly upstream of ChiselTop, between a dedicated `ui_in` pin and the core's byte-input port, and reports framing errors and overruns as single-cycle pulses.

## Interface
Parameters:
- `FREQ_HZ`, 50000000, clock frequency in Hz.
- `BAUD`, 115200, line rate; divisor `DIV = FREQ_HZ / BAUD` (truncated; must be ≥ 4, even values recommended).

Ports:
- `clock`  input  1  single clock domain.
- `reset`  input  1  asynchronous, active-high reset.
- `io_rx`  input  1  serial line, idle high, asynchronous to `clock`.
- `io_out_bits`  output  8  received byte at buffer head.
- `io_out_valid`  output  1  buffer non-empty.
- `io_out_ready`  input  1  consumer accepts head byte when high with `io_out_valid`.
- `io_frame_err`  output  1  one-cycle pulse: stop bit sampled low (or parity fail, see Configuration).
- `io_overrun`  output  1  one-cycle pulse: good byte dropped because buffer full.

## Operation
- `io_rx` passes through a 2-flop synchroniser (both flops reset to 1); FSM uses synchronised value `rxs`.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: `rxs == 0` → START, load counter with `DIV/2 - 1`.
- START: on counter expiry sample `rxs`; 0 → DATA (counter `DIV - 1`, bit index 0); 1 → IDLE (glitch rejected, no flag).
- DATA: on each expiry shift `rxs` in LSB first; after bit 7 → STOP.
- STOP: on expiry sample `rxs`; 1 → push byte, IDLE; 0 → `io_frame_err` pulse, byte discarded, WAIT_HIGH.
- WAIT_HIGH: remain until `rxs == 1`, then IDLE (prevents a break condition retriggering).
- Buffer: 2 entries, FIFO order. Pop when `io_out_valid && io_out_ready`. Push of a good byte when full and no pop in that cycle → byte dropped, `io_overrun` pulse; buffer contents unchanged.
- Simultaneous push and pop when full: pop first, push accepted, no overrun. Push and pop when one entry: count stays 1, head advances to new byte.
- `io_out_bits` is undefined-but-stable (holds last head) when `io_out_valid` is 0; it never changes while valid is high and not popped.

## Timing
- Reset values: `io_out_bits` 0x00, `io_out_valid` 0, `io_frame_err` 0, `io_overrun` 0; FSM IDLE; buffer empty; synchroniser 1.
- Reset mid-frame aborts the frame and empties the buffer; no flags after release.
- Pin falling edge at cycle 0 → `rxs` low at cycle 2 → start sample at 2 + DIV/2 → data samples every DIV → stop sample at 2 + DIV/2 + 9·DIV.
- `io_out_valid` (or error pulse) asserts the cycle after the stop sample: latency 3 + DIV/2 + 9·DIV cycles.
- Next frame's start edge accepted from the cycle after the stop sample (IDLE).
- Pop takes effect at the clock edge where valid && ready; new head/valid visible next cycle.
- All outputs driven from registers.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1; after bit 7 an extra PARITY state samples one bit at DIV spacing; even-parity mismatch → `io_frame_err` pulse, byte discarded, STOP still sampled (low stop also flags once, not twice). Latency grows by DIV.
- Not defined: 8N1 as above, no PARITY state.

## Test plan
- FREQ_HZ=16, BAUD=1 (DIV=16), ready=1; send 0xA5 with pin fall at cycle 0 → valid high at cycle 155 with bits 0xA5 for one cycle, no flags.
- 0x3C then 0x81 back-to-back, ready=0 → valid stays high, head 0x3C; raise ready → 0x3C then 0x81, then valid 0.
- Three bytes with ready=0 → third frame's completion pulses `io_overrun`; buffer yields 0x01, 0x02 only.
- Frame 0x55 with stop bit forced 0, line held low 40 cycles → one `io_frame_err` pulse, valid stays 0, no new frame until line high.
- 4-cycle low glitch on idle line → returns IDLE, no valid, no flags; reset asserted mid-frame → all outputs 0, next clean 0x7E received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity 1 → received; parity 0 → `io_frame_err`, no valid.

Source files
------------

// File: rtl/wildcat_uart_rx.sv
// UART receive front end: 2-flop synchroniser, 8N1 deserialiser, 2-entry ready/valid byte buffer.
// Latency: pin fall to io_out_valid is 3 + DIV/2 + 9*DIV cycles (+DIV when UART_RX_PARITY_EN is defined).
// Backpressure: io_out_ready low holds the head byte; a good byte arriving with the buffer full is dropped and pulses io_overrun.
module wildcat_uart_rx #(
    parameter int FREQ_HZ = 50000000,
    parameter int BAUD    = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rx,
    output logic [7:0] io_out_bits,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic       io_frame_err,
    output logic       io_overrun
);

    localparam int DIV = FREQ_HZ / BAUD;
    localparam int CW  = $clog2(DIV) + 1;
    localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic          sync1_q, sync2_q;
    logic          rxs;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          expired;
    logic          push_req, ferr_set;
    logic [7:0]    head_q, head_d, tail_q, tail_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic          valid_q, ovr_q, ovr_d, ferr_q;
    logic          pop;
`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    assign rxs     = sync2_q;
    assign expired = (cnt_q == '0);
    assign pop     = valid_q && io_out_ready;

    // Synchronise the asynchronous pin; idle-high reset avoids a false start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= io_rx;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM state and bit-timing datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Next state: count down to the mid-bit sample point, then act on the sampled level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = HALF_LD;
                end
            end
            S_START: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxs) begin
                    state_d = S_DATA;
                    cnt_d   = FULL_LD;
                    bit_d   = '0;
                end else begin
                    // Line went back high before mid start bit: treat as a glitch.
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Even parity: data bits plus parity bit must contain an even number of ones.
                    par_err_d = ^{shift_q, rxs};
                    cnt_d     = FULL_LD;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = rxs ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must not start a new frame.
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: at the stop sample either deliver the byte or flag exactly one framing error.
    always_comb begin
        push_req = 1'b0;
        ferr_set = 1'b0;
        if (state_q == S_STOP && expired) begin
            if (!rxs) begin
                ferr_set = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
                ferr_set = par_err_q;
                push_req = !par_err_q;
`else
                push_req = 1'b1;
`endif
            end
        end
    end

    // Two-entry buffer: head feeds the port directly and keeps its value when emptied.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        bcnt_d = bcnt_q;
        ovr_d  = 1'b0;
        case (bcnt_q)
            2'd0: begin
                if (push_req) begin
                    head_d = shift_q;
                    bcnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_req && pop) begin
                    head_d = shift_q;
                end else if (pop) begin
                    bcnt_d = 2'd0;
                end else if (push_req) begin
                    tail_d = shift_q;
                    bcnt_d = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push_req) begin
                        tail_d = shift_q;
                    end else begin
                        bcnt_d = 2'd1;
                    end
                end else if (push_req) begin
                    ovr_d = 1'b1;
                end
            end
        endcase
    end

    // Buffer and flag registers so every output comes straight from a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            bcnt_q  <= bcnt_d;
            valid_q <= (bcnt_d != 2'd0);
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_set;
        end
    end

    assign io_out_bits  = head_q;
    assign io_out_valid = valid_q;
    assign io_frame_err = ferr_q;
    assign io_overrun   = ovr_q;

endmodule

// File: tb/tb_wildcat_uart_rx.sv
// Directed bench for wildcat_uart_rx at DIV=16.
// Latency: frames are driven bit by bit; completions are logged by a negedge monitor.
// Backpressure: io_out_ready is toggled by the directed steps to fill and drain the buffer.
module tb_wildcat_uart_rx;

    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 3 + DIV / 2 + 10 * DIV;
`else
    localparam int LAT = 3 + DIV / 2 + 9 * DIV;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_rx = 1'b1;
    logic [7:0] io_out_bits;
    logic       io_out_valid;
    logic       io_out_ready = 1'b1;
    logic       io_frame_err;
    logic       io_overrun;

    int cmp_n = 0;
    int bad_n = 0;
    int cyc = 0;
    int fall_cyc = 0;
    logic [7:0] popq[$];
    int popcyc[$];
    int ferr_n = 0;
    int ovr_n = 0;
    int ovr_cyc = 0;
    int qb, fb, ob;
`ifdef UART_RX_PARITY_EN
    logic par_bit = 1'b0;
`endif

    wildcat_uart_rx #(.FREQ_HZ(16), .BAUD(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_rx        (io_rx),
        .io_out_bits  (io_out_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_frame_err (io_frame_err),
        .io_overrun   (io_overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Log accepted bytes and flag pulses away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (io_out_valid && io_out_ready) begin
                popq.push_back(io_out_bits);
                popcyc.push_back(cyc);
            end
            if (io_frame_err) ferr_n <= ferr_n + 1;
            if (io_overrun) begin
                ovr_n   <= ovr_n + 1;
                ovr_cyc <= cyc;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        fall_cyc = cyc;
        io_rx = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            io_rx = d[i];
            wait_cyc(DIV);
        end
`ifdef UART_RX_PARITY_EN
        io_rx = par_bit;
        wait_cyc(DIV);
`endif
        io_rx = stop_b;
        wait_cyc(DIV);
    endtask

    initial begin
        // Reset state.
        wait_cyc(3);
        check("rst_bits", {24'd0, io_out_bits}, 32'h00);
        check("rst_valid", {31'd0, io_out_valid}, 32'd0);
        check("rst_ferr", {31'd0, io_frame_err}, 32'd0);
        check("rst_ovr", {31'd0, io_overrun}, 32'd0);
        reset = 1'b0;
        wait_cyc(5);

        // Single byte, ready high: one-cycle valid at the exact latency.
`ifdef UART_RX_PARITY_EN
        par_bit = 1'b0;
`endif
        qb = popq.size(); fb = ferr_n; ob = ovr_n;
        send_frame(8'hA5, 1'b1);
        wait_cyc(10);
        check("a5_count", popq.size() - qb, 32'd1);
        check("a5_data", {24'd0, popq[qb]}, 32'hA5);
        check("a5_cycle", popcyc[qb] - fall_cyc, LAT);
        check("a5_flags", (ferr_n - fb) + (ovr_n - ob), 32'd0);

        // Two bytes with ready low: head holds the first, then drains in order.
        io_out_ready = 1'b0;
        qb = popq.size();
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        wait_cyc(5);
        check("bp_valid", {31'd0, io_out_valid}, 32'd1);
        check("bp_head", {24'd0, io_out_bits}, 32'h3C);
        wait_cyc(7);
        check("bp_head_stable", {24'd0, io_out_bits}, 32'h3C);
        io_out_ready = 1'b1;
        wait_cyc(4);
        check("bp_count", popq.size() - qb, 32'd2);
        check("bp_first", {24'd0, popq[qb]}, 32'h3C);
        check("bp_second", {24'd0, popq[qb+1]}, 32'h81);
        check("bp_empty", {31'd0, io_out_valid}, 32'd0);

        // Three bytes into a full buffer: third is dropped with an overrun pulse.
        io_out_ready = 1'b0;
        qb = popq.size(); ob = ovr_n;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        wait_cyc(5);
        check("ovr_count", ovr_n - ob, 32'd1);
        check("ovr_cycle", ovr_cyc - fall_cyc, LAT);
        io_out_ready = 1'b1;
        wait_cyc(5);
        check("ovr_drain_n", popq.size() - qb, 32'd2);
        check("ovr_drain0", {24'd0, popq[qb]}, 32'h01);
        check("ovr_drain1", {24'd0, popq[qb+1]}, 32'h02);
        check("ovr_empty", {31'd0, io_out_valid}, 32'd0);

        // Low stop bit followed by a long break: one error, no byte, no retrigger.
        qb = popq.size(); fb = ferr_n;
        send_frame(8'h55, 1'b0);
        wait_cyc(200);
        check("fe_count", ferr_n - fb, 32'd1);
        check("fe_nobyte", popq.size() - qb, 32'd0);
        io_rx = 1'b1;
        wait_cyc(30);
        check("fe_after_high", ferr_n - fb, 32'd1);
        check("fe_valid", {31'd0, io_out_valid}, 32'd0);

        // Short glitch on an idle line is ignored.
        qb = popq.size(); fb = ferr_n; ob = ovr_n;
        io_rx = 1'b0;
        wait_cyc(4);
        io_rx = 1'b1;
        wait_cyc(30);
        check("gl_nobyte", popq.size() - qb, 32'd0);
        check("gl_flags", (ferr_n - fb) + (ovr_n - ob), 32'd0);

        // Reset mid-frame with a byte buffered: everything clears, next frame is clean.
        io_out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_cyc(5);
        check("mr_prefill", {31'd0, io_out_valid}, 32'd1);
        io_rx = 1'b0;
        wait_cyc(40);
        reset = 1'b1;
        #1;
        check("mr_valid", {31'd0, io_out_valid}, 32'd0);
        check("mr_bits", {24'd0, io_out_bits}, 32'h00);
        io_rx = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        fb = ferr_n; ob = ovr_n; qb = popq.size();
        wait_cyc(20);
        check("mr_quiet", (ferr_n - fb) + (ovr_n - ob) + {31'd0, io_out_valid}, 32'd0);
        io_out_ready = 1'b1;
        send_frame(8'h7E, 1'b1);
        wait_cyc(10);
        check("mr_count", popq.size() - qb, 32'd1);
        check("mr_data", {24'd0, popq[qb]}, 32'h7E);
        check("mr_flags", (ferr_n - fb) + (ovr_n - ob), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones so the parity bit must be 1.
        qb = popq.size(); fb = ferr_n;
        par_bit = 1'b1;
        send_frame(8'h07, 1'b1);
        wait_cyc(10);
        check("par_ok_n", popq.size() - qb, 32'd1);
        check("par_ok_data", {24'd0, popq[qb]}, 32'h07);
        check("par_ok_ferr", ferr_n - fb, 32'd0);
        qb = popq.size();
        par_bit = 1'b0;
        send_frame(8'h07, 1'b1);
        wait_cyc(10);
        check("par_bad_ferr", ferr_n - fb, 32'd1);
        check("par_bad_n", popq.size() - qb, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
